// File: rtl/control_pipe.sv
// Decode/execute/memory/write-back control pipeline for a small core.
// Multi-cycle multiply holds execute and stalls decode until it drains.
module control_pipe #(
    parameter int MUL_CYCLES = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_d,
    input  logic             valid_d,
    input  logic             stall_in,
    input  logic             flush_in,
    output logic [4:0]       alu_control_e,
    output logic [1:0]       imm_src_e,
    output logic             alu_src_e,
    output logic             branch_e,
    output logic             valid_e,
    output logic             valid_m,
    output logic             valid_w,
    output logic             mem_write_m,
    output logic [1:0]       mem_to_reg_m,
    output logic [1:0]       mem_to_reg_w,
    output logic             reg_write_m,
    output logic             reg_write_w,
    output logic             stall_d,
    output logic             illegal_d,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic {
        IDLE,
        MUL_BUSY
    } state_t;

    localparam bit MUL_MULTI = (MUL_CYCLES > 1);
    localparam logic [3:0] CNT_INIT =
        MUL_MULTI ? 4'(MUL_CYCLES - 2) : 4'd0;

    state_t     state;
    logic [3:0] mul_cnt;

    logic       legal;
    logic       dec_valid;
    logic       dec_mul;
    logic [4:0] dec_alu;
    logic [1:0] dec_imm;
    logic       dec_alu_src;
    logic       dec_branch;
    logic       dec_mem_write;
    logic [1:0] dec_mem_to_reg;
    logic       dec_reg_write;

    logic       busy;
    logic       accept;

    logic       mem_write_e;
    logic [1:0] mem_to_reg_e;
    logic       reg_write_e;

    always_comb begin
        legal = 1'b0;
        case (opcode_d)
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b001001, 6'b001010, 6'b001011, 6'b001100,
            6'b001110,
            6'b010001, 6'b010010, 6'b010011, 6'b010100,
            6'b011001, 6'b011010,
            6'b101001, 6'b101010, 6'b101011,
            6'b111000, 6'b111001, 6'b111010, 6'b111011,
            6'b111100, 6'b111101, 6'b111110: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
    end

    assign dec_valid = valid_d & legal;
    assign illegal_d = valid_d & ~legal;

    // Only the two multiply encodings share alu_control 00011.
    assign dec_mul = dec_valid &
        ((opcode_d == 6'b000011) | (opcode_d == 6'b001011));

    always_comb begin
        dec_alu        = 5'd0;
        dec_imm        = 2'b00;
        dec_alu_src    = 1'b0;
        dec_branch     = 1'b0;
        dec_mem_write  = 1'b0;
        dec_mem_to_reg = 2'b00;
        dec_reg_write  = 1'b0;
        if (dec_valid) begin
            dec_alu     = {opcode_d[5:4], opcode_d[2:0]};
            dec_alu_src = opcode_d[3];
            dec_branch  = (opcode_d[5:3] == 3'b111);
            unique case (1'b1)
                (opcode_d[5:3] == 3'b011): dec_imm = 2'b01;
                (opcode_d[5:3] == 3'b101): dec_imm = 2'b10;
                (opcode_d[5:3] == 3'b111): dec_imm = 2'b11;
                default:                   dec_imm = 2'b00;
            endcase
            unique case (1'b1)
                (opcode_d == 6'b000100),
                (opcode_d == 6'b001100):   dec_mem_to_reg = 2'b10;
                (opcode_d == 6'b101001):   dec_mem_to_reg = 2'b01;
                default:                   dec_mem_to_reg = 2'b00;
            endcase
            dec_mem_write = (opcode_d == 6'b101011);
            dec_reg_write = ~((opcode_d == 6'b101011) |
                              (opcode_d[5:3] == 3'b111));
        end
    end

    assign busy    = (state == MUL_BUSY);
    assign accept  = ~busy & ~flush_in & ~stall_in;
    assign stall_d = stall_in | busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_control_e <= 5'd0;
            imm_src_e     <= 2'b00;
            alu_src_e     <= 1'b0;
            branch_e      <= 1'b0;
            valid_e       <= 1'b0;
            mem_write_e   <= 1'b0;
            mem_to_reg_e  <= 2'b00;
            reg_write_e   <= 1'b0;
        end else if (!busy) begin
            if (accept) begin
                alu_control_e <= dec_alu;
                imm_src_e     <= dec_imm;
                alu_src_e     <= dec_alu_src;
                branch_e      <= dec_branch;
                valid_e       <= dec_valid;
                mem_write_e   <= dec_mem_write;
                mem_to_reg_e  <= dec_mem_to_reg;
                reg_write_e   <= dec_reg_write;
            end else begin
                alu_control_e <= 5'd0;
                imm_src_e     <= 2'b00;
                alu_src_e     <= 1'b0;
                branch_e      <= 1'b0;
                valid_e       <= 1'b0;
                mem_write_e   <= 1'b0;
                mem_to_reg_e  <= 2'b00;
                reg_write_e   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_m      <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 2'b00;
            reg_write_m  <= 1'b0;
        end else if (busy) begin
            valid_m      <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 2'b00;
            reg_write_m  <= 1'b0;
        end else begin
            valid_m      <= valid_e;
            mem_write_m  <= mem_write_e;
            mem_to_reg_m <= mem_to_reg_e;
            reg_write_m  <= reg_write_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_w      <= 1'b0;
            mem_to_reg_w <= 2'b00;
            reg_write_w  <= 1'b0;
        end else begin
            valid_w      <= valid_m;
            mem_to_reg_w <= mem_to_reg_m;
            reg_write_w  <= reg_write_m;
        end
    end

    // Busy is entered on the edge that loads the multiply into E, so the
    // multiply occupies E for the entry cycle plus MUL_CYCLES-1 busy cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mul_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (MUL_MULTI && accept && dec_mul) begin
                        state   <= MUL_BUSY;
                        mul_cnt <= CNT_INIT;
                    end
                end
                MUL_BUSY: begin
                    if (mul_cnt == 4'd0) begin
                        state <= IDLE;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mul_cnt <= 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_cnt <= '0;
        end else if (accept && illegal_d && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_control_pipe.sv
// Directed bench for control_pipe with a write-back scoreboard.
module tb_control_pipe;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode_d;
    logic       valid_d;
    logic       stall_in;
    logic       flush_in;
    logic [4:0] alu_control_e;
    logic [1:0] imm_src_e;
    logic       alu_src_e;
    logic       branch_e;
    logic       valid_e;
    logic       valid_m;
    logic       valid_w;
    logic       mem_write_m;
    logic [1:0] mem_to_reg_m;
    logic [1:0] mem_to_reg_w;
    logic       reg_write_m;
    logic       reg_write_w;
    logic       stall_d;
    logic       illegal_d;
    logic [7:0] illegal_cnt;

    logic [4:0] s_alu_control_e;
    logic [1:0] s_imm_src_e;
    logic       s_alu_src_e;
    logic       s_branch_e;
    logic       s_valid_e;
    logic       s_valid_m;
    logic       s_valid_w;
    logic       s_mem_write_m;
    logic [1:0] s_mem_to_reg_m;
    logic [1:0] s_mem_to_reg_w;
    logic       s_reg_write_m;
    logic       s_reg_write_w;
    logic       s_stall_d;
    logic       s_illegal_d;
    logic [7:0] s_illegal_cnt;

    int checks = 0;
    int errors = 0;
    logic [2:0] sb[$];

    control_pipe #(.MUL_CYCLES(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d),
        .valid_d(valid_d), .stall_in(stall_in), .flush_in(flush_in),
        .alu_control_e(alu_control_e), .imm_src_e(imm_src_e),
        .alu_src_e(alu_src_e), .branch_e(branch_e),
        .valid_e(valid_e), .valid_m(valid_m), .valid_w(valid_w),
        .mem_write_m(mem_write_m), .mem_to_reg_m(mem_to_reg_m),
        .mem_to_reg_w(mem_to_reg_w), .reg_write_m(reg_write_m),
        .reg_write_w(reg_write_w), .stall_d(stall_d),
        .illegal_d(illegal_d), .illegal_cnt(illegal_cnt)
    );

    control_pipe #(.MUL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode_d(opcode_d),
        .valid_d(valid_d), .stall_in(stall_in), .flush_in(flush_in),
        .alu_control_e(s_alu_control_e), .imm_src_e(s_imm_src_e),
        .alu_src_e(s_alu_src_e), .branch_e(s_branch_e),
        .valid_e(s_valid_e), .valid_m(s_valid_m), .valid_w(s_valid_w),
        .mem_write_m(s_mem_write_m), .mem_to_reg_m(s_mem_to_reg_m),
        .mem_to_reg_w(s_mem_to_reg_w), .reg_write_m(s_reg_write_m),
        .reg_write_w(s_reg_write_w), .stall_d(s_stall_d),
        .illegal_d(s_illegal_d), .illegal_cnt(s_illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {legal, reg_write, mem_to_reg}.
    function automatic logic [3:0] model(input logic [5:0] op);
        int  v;
        logic lg;
        logic rw;
        logic [1:0] mtr;
        v  = int'(op);
        lg = (v >= 1 && v <= 4) || (v >= 9 && v <= 12) || v == 14 ||
             (v >= 17 && v <= 20) || v == 25 || v == 26 ||
             (v >= 41 && v <= 43) || (v >= 56 && v <= 62);
        rw = lg && !(v == 43 || v >= 56);
        mtr = !lg ? 2'b00 : (v == 4 || v == 12) ? 2'b10 :
              (v == 41) ? 2'b01 : 2'b00;
        return {lg, rw, mtr};
    endfunction

    task automatic drv(input logic [5:0] op, input logic v,
                       input logic fl, input logic st, input logic acc);
        logic [3:0] m;
        opcode_d = op;
        valid_d  = v;
        flush_in = fl;
        stall_in = st;
        m = model(op);
        if (acc && v && m[3]) sb.push_back(m[2:0]);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && valid_w) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL wb_unexpected: observed valid_w 1 expected 0");
            end else begin
                chk("wb_ctrl", {29'd0, reg_write_w, mem_to_reg_w},
                    {29'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        opcode_d = 6'd0;
        valid_d = 1'b0;
        stall_in = 1'b0;
        flush_in = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid_e", valid_e, 0);
        chk("rst_valid_m", valid_m, 0);
        chk("rst_valid_w", valid_w, 0);
        chk("rst_alu", alu_control_e, 0);
        chk("rst_cnt", illegal_cnt, 0);
        chk("rst_stall", stall_d, 0);
        tick();
        rst_n = 1'b1;

        // ADDI
        drv(6'b001001, 1, 0, 0, 1);
        tick();
        chk("addi_alu", alu_control_e, 5'b00001);
        chk("addi_alu_src", alu_src_e, 1);
        chk("addi_imm", imm_src_e, 2'b00);
        chk("addi_valid_e", valid_e, 1);
        drv(6'd0, 0, 0, 0, 0);
        tick();
        tick();
        chk("addi_rw_w", reg_write_w, 1);
        chk("addi_mtr_w", mem_to_reg_w, 2'b00);
        chk("addi_valid_w", valid_w, 1);

        // STR then JMP
        drv(6'b101011, 1, 0, 0, 1);
        tick();
        drv(6'b111000, 1, 0, 0, 1);
        tick();
        chk("str_mw_m", mem_write_m, 1);
        chk("str_rw_m", reg_write_m, 0);
        chk("jmp_branch", branch_e, 1);
        chk("jmp_imm", imm_src_e, 2'b11);
        chk("jmp_alu_src", alu_src_e, 1);
        drv(6'd0, 0, 0, 0, 0);
        tick();
        chk("jmp_rw_m", reg_write_m, 0);
        chk("jmp_mw_m", mem_write_m, 0);
        chk("jmp_valid_m", valid_m, 1);

        // MUL with ADD behind it; flush during busy is ignored
        drv(6'b000011, 1, 0, 0, 1);
        tick();
        chk("mul_e1_alu", alu_control_e, 5'b00011);
        chk("mul_e1_valid", valid_e, 1);
        drv(6'b000001, 1, 1, 0, 0);
        chk("mul_c1_stall", stall_d, 1);
        chk("mul1_c1_stall", s_stall_d, 0);
        tick();
        chk("mul_e2_alu", alu_control_e, 5'b00011);
        chk("mul_e2_valid", valid_e, 1);
        chk("mul_e2_bubble", valid_m, 0);
        chk("mul1_m_valid", s_valid_m, 1);
        chk("mul1_e_flushed", s_valid_e, 0);
        drv(6'b000001, 1, 0, 0, 0);
        chk("mul_c2_stall", stall_d, 1);
        tick();
        chk("mul_e3_alu", alu_control_e, 5'b00011);
        chk("mul_e3_bubble", valid_m, 0);
        drv(6'b000001, 1, 0, 0, 1);
        chk("mul_c3_stall", stall_d, 0);
        tick();
        chk("add_e_alu", alu_control_e, 5'b00001);
        chk("add_e_valid", valid_e, 1);
        chk("mul_m_valid", valid_m, 1);
        chk("mul_m_rw", reg_write_m, 1);

        // flush and stall squash decode
        drv(6'b110000, 1, 1, 0, 0);
        chk("fl_illegal_d", illegal_d, 1);
        tick();
        chk("fl_valid_e", valid_e, 0);
        chk("fl_cnt", illegal_cnt, 0);
        drv(6'b000100, 1, 1, 1, 0);
        chk("fs_stall", stall_d, 1);
        tick();
        chk("fs_valid_e", valid_e, 0);
        chk("fs_cnt", illegal_cnt, 0);
        drv(6'b000100, 1, 0, 0, 1);
        tick();
        chk("ldr_valid_e", valid_e, 1);
        chk("ldr_alu", alu_control_e, 5'b00100);
        chk("ldr_alu_src", alu_src_e, 0);

        // illegal opcode saturation
        for (int i = 0; i < 259; i++) begin
            drv(6'b110000, 1, 0, 0, 0);
            chk("ill_d", illegal_d, 1);
            tick();
            chk("ill_valid_e", valid_e, 0);
            if (i == 0) chk("ill_cnt_first", illegal_cnt, 1);
            if (i == 253) chk("ill_cnt_254", illegal_cnt, 254);
        end
        chk("ill_cnt_sat", illegal_cnt, 8'hFF);
        chk("ill_valid_m", valid_m, 0);
        chk("ill_valid_w", valid_w, 0);

        // reset in the middle of a multiply
        drv(6'b001011, 1, 0, 0, 1);
        tick();
        drv(6'd0, 0, 0, 0, 0);
        chk("rmul_stall", stall_d, 1);
        chk("rmul_alu", alu_control_e, 5'b00011);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        chk("rmul_valid_e", valid_e, 0);
        chk("rmul_alu0", alu_control_e, 0);
        chk("rmul_cnt", illegal_cnt, 0);
        chk("rmul_stall0", stall_d, 0);
        chk("rmul_valid_m", valid_m, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_stall", stall_d, 0);
        chk("rel_valid_e", valid_e, 0);

        // LDRB-style load after reset flows through cleanly
        drv(6'b001100, 1, 0, 0, 1);
        tick();
        drv(6'd0, 0, 0, 0, 0);
        tick();
        tick();
        chk("post_mtr_w", mem_to_reg_w, 2'b10);
        tick();
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
